bip_fetch_unit: RTL and testbench

- Upstream neighbour of the BIP instruction decoder.
- Owns the program counter and fetches 16-bit instructions from the synchronous program ROM.
- Splits each instruction into opcode and operand, presents them to the decoder for one EXEC cycle, and advances or halts from the decoder's o_wrPc.
- Also provides run control (start/halt), an illegal-opcode flag and a cycle counter for debug.

---
 rtl/bip_pkg.sv | 38 +++
 rtl/bip_sign_extend.sv | 12 +
 rtl/bip_fetch_unit.sv | 129 ++++++++++++
 tb/tb_bip_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: instruction field layout,
// opcode values and the fetch unit state encoding.
package bip_pkg;

  // Default field widths of the 16-bit BIP instruction word.
  localparam int DEF_NB_OPCODE  = 5;
  localparam int DEF_NB_OPERAND = 11;
  localparam int DEF_NB_INSTR   = DEF_NB_OPCODE + DEF_NB_OPERAND;
  localparam int DEF_NB_ADDR    = 11;
  localparam int DEF_NB_DATA    = 16;
  localparam int DEF_NB_CYCLES  = 16;

  // Field positions inside the instruction word.
  localparam int OPCODE_MSB  = DEF_NB_INSTR - 1;
  localparam int OPCODE_LSB  = DEF_NB_OPERAND;
  localparam int OPERAND_MSB = DEF_NB_OPERAND - 1;
  localparam int OPERAND_LSB = 0;

  // Opcode values understood by the decoder.
  localparam logic [DEF_NB_OPCODE-1:0] OP_HALT = 5'b00000;
  localparam logic [DEF_NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [DEF_NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [DEF_NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [DEF_NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [DEF_NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [DEF_NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [DEF_NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  // Fetch unit sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } fetchState_t;

endpackage

// File: rtl/bip_sign_extend.sv
// Replicates the operand sign bit to widen an immediate to the data width.
module bip_sign_extend #(
  parameter int NB_IN  = 11,
  parameter int NB_OUT = 16
) (
  input  logic [NB_IN-1:0]  operand,
  output logic [NB_OUT-1:0] extended
);

  assign extended = {{(NB_OUT - NB_IN){operand[NB_IN-1]}}, operand};

endmodule

// File: rtl/bip_fetch_unit.sv
// BIP fetch unit: owns the PC, reads the synchronous program ROM, holds the
// instruction register for the decoder and provides run control and debug
// status (halted, sticky illegal-opcode flag, saturating cycle counter).
module bip_fetch_unit
  import bip_pkg::*;
#(
  parameter int NB_OPCODE  = DEF_NB_OPCODE,
  parameter int NB_OPERAND = DEF_NB_OPERAND,
  parameter int NB_INSTR   = DEF_NB_INSTR,
  parameter int NB_ADDR    = DEF_NB_ADDR,
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int NB_CYCLES  = DEF_NB_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic [NB_ADDR-1:0]    o_rom_addr,
  output logic                  o_rom_en,
  input  logic [NB_INSTR-1:0]   i_rom_data,
  output logic [NB_OPCODE-1:0]  o_opcode,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic [NB_DATA-1:0]    o_operand_ext,
  output logic                  o_valid,
  input  logic                  i_wrPc,
  output logic [NB_ADDR-1:0]    o_pc,
  output logic                  o_halted,
  output logic                  o_illegal,
  output logic [NB_CYCLES-1:0]  o_cycles
);

  fetchState_t           stateReg;
  fetchState_t           stateNext;
  logic [NB_ADDR-1:0]    pc;
  logic [NB_INSTR-1:0]   ir;
  logic                  illegal;
  logic [NB_CYCLES-1:0]  cycles;
  logic [NB_OPCODE-1:0]  opcodeField;
  logic [NB_OPERAND-1:0] operandField;
  logic                  running;
  logic                  restart;

  assign opcodeField  = ir[NB_INSTR-1 -: NB_OPCODE];
  assign operandField = ir[NB_OPERAND-1:0];

  // Cycles in which an instruction is being processed and therefore counted.
  assign running = (stateReg == ST_FETCH) || (stateReg == ST_DECODE) ||
                   (stateReg == ST_EXEC);

  // A start pulse while halted rewinds the program and clears debug state.
  assign restart = (stateReg == ST_HALT) && i_start;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!i_rst_n) begin
      stateReg <= ST_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic: fixed FETCH/DECODE/EXEC cadence, decoder decides
  // whether to continue or halt.
  always_comb begin
    // NOTE: default assigned first so every path drives stateNext and no
    // latch is inferred.
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:   if (i_start) stateNext = ST_FETCH;
      ST_FETCH:  stateNext = ST_DECODE;
      ST_DECODE: stateNext = ST_EXEC;
      ST_EXEC:   stateNext = i_wrPc ? ST_FETCH : ST_HALT;
      ST_HALT:   if (i_start) stateNext = ST_FETCH;
      default:   stateNext = ST_IDLE;
    endcase
  end

  // PC, instruction register and illegal flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else if (restart) begin
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else if (stateReg == ST_DECODE) begin
      ir <= i_rom_data;
    end else if (stateReg == ST_EXEC) begin
      if (i_wrPc) begin
        pc <= pc + NB_ADDR'(1);
      end else if (opcodeField != '0) begin
        illegal <= 1'b1;
      end
    end
  end

  // Saturating count of active cycles since reset or the last restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycles <= '0;
    end else if (restart) begin
      cycles <= '0;
    end else if (running && (cycles != '1)) begin
      cycles <= cycles + NB_CYCLES'(1);
    end
  end

  bip_sign_extend #(
    .NB_IN  (NB_OPERAND),
    .NB_OUT (NB_DATA)
  ) u_signExtend (
    .operand  (operandField),
    .extended (o_operand_ext)
  );

  assign o_rom_addr = pc;
  assign o_rom_en   = (stateReg == ST_FETCH);
  assign o_opcode   = opcodeField;
  assign o_operand  = operandField;
  assign o_valid    = (stateReg == ST_EXEC);
  assign o_pc       = pc;
  assign o_halted   = (stateReg == ST_HALT);
  assign o_illegal  = illegal;
  assign o_cycles   = cycles;

endmodule

// File: tb/tb_bip_fetch_unit.sv
// Bench for bip_fetch_unit: a program-level reference model fills a
// scoreboard of expected EXEC cycles, a monitor compares at every o_valid.
// Two extra instances cover PC wrap (NB_ADDR=2) and counter saturation
// (NB_CYCLES=4).
module tb_bip_fetch_unit;

  typedef struct {
    int          idx;
    logic [10:0] pc;
    logic [4:0]  op;
    logic [10:0] operand;
    logic [15:0] ext;
  } expItem_t;

  int checks = 0;
  int errors = 0;
  int negCount = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] romAddr;
  logic        romEn;
  logic [15:0] romData = '0;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic [15:0] operandExt;
  logic        valid;
  logic        wrPc;
  logic [10:0] pc;
  logic        halted;
  logic        illegal;
  logic [15:0] cycles;

  logic [15:0] rom [0:2047];
  expItem_t    mainQ[$];
  expItem_t    e;

  bip_fetch_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_rom_addr(romAddr), .o_rom_en(romEn), .i_rom_data(romData),
    .o_opcode(opcode), .o_operand(operand), .o_operand_ext(operandExt),
    .o_valid(valid), .i_wrPc(wrPc), .o_pc(pc), .o_halted(halted),
    .o_illegal(illegal), .o_cycles(cycles)
  );

  // Synchronous program ROM: data appears the cycle after the enable.
  always @(posedge clk) if (romEn) romData <= rom[romAddr];

  // Decoder model: known opcodes other than HALT continue execution.
  function automatic bit continues(input logic [4:0] op);
    return (op >= 5'd1) && (op <= 5'd7);
  endfunction

  assign wrPc = valid && continues(opcode);

  // ---------------- auxiliary instances ----------------
  logic        auxRst_n = 1'b0;
  logic        auxStart = 1'b0;
  logic [15:0] auxRomData = 16'h2801;   // ADDI 1 at every address

  logic [1:0]  wRomAddr;
  logic        wRomEn, wValid, wWrPc, wHalted, wIllegal;
  logic [4:0]  wOpcode;
  logic [10:0] wOperand;
  logic [15:0] wOperandExt, wCycles;
  logic [1:0]  wPc;

  logic [10:0] sRomAddr;
  logic        sRomEn, sValid, sWrPc, sHalted, sIllegal;
  logic [4:0]  sOpcode;
  logic [10:0] sOperand;
  logic [15:0] sOperandExt;
  logic [10:0] sPc;
  logic [3:0]  sCycles;

  bip_fetch_unit #(.NB_ADDR(2)) dutWrap (
    .i_clk(clk), .i_rst_n(auxRst_n), .i_start(auxStart),
    .o_rom_addr(wRomAddr), .o_rom_en(wRomEn), .i_rom_data(auxRomData),
    .o_opcode(wOpcode), .o_operand(wOperand), .o_operand_ext(wOperandExt),
    .o_valid(wValid), .i_wrPc(wWrPc), .o_pc(wPc), .o_halted(wHalted),
    .o_illegal(wIllegal), .o_cycles(wCycles)
  );

  bip_fetch_unit #(.NB_CYCLES(4)) dutSat (
    .i_clk(clk), .i_rst_n(auxRst_n), .i_start(auxStart),
    .o_rom_addr(sRomAddr), .o_rom_en(sRomEn), .i_rom_data(auxRomData),
    .o_opcode(sOpcode), .o_operand(sOperand), .o_operand_ext(sOperandExt),
    .o_valid(sValid), .i_wrPc(sWrPc), .o_pc(sPc), .o_halted(sHalted),
    .o_illegal(sIllegal), .o_cycles(sCycles)
  );

  assign wWrPc = wValid && continues(wOpcode);
  assign sWrPc = sValid && continues(sOpcode);

  logic [1:0] wrapQ[$];
  bit         wrapOn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=valid required=no valid", name);
  endtask

  // Monitor: every EXEC cycle of each instance is matched against the queue.
  always @(negedge clk) begin
    if (valid) begin
      if (mainQ.size() == 0) unexpected("main_exec");
      else begin
        e = mainQ.pop_front();
        check("exec_cycle", negCount, e.idx);
        check("exec_pc", 32'(pc), 32'(e.pc));
        check("exec_opcode", 32'(opcode), 32'(e.op));
        check("exec_operand", 32'(operand), 32'(e.operand));
        check("exec_operand_ext", 32'(operandExt), 32'(e.ext));
      end
    end
    if (wrapOn && wValid) begin
      if (wrapQ.size() == 0) unexpected("wrap_exec");
      else check("wrap_pc", 32'(wPc), 32'(wrapQ.pop_front()));
    end
    negCount++;
  end

  // Program-level model: walk the ROM from address 0 until the decoder stops.
  task automatic runModel(input int n0, output int nExec, output logic [10:0] haltPc,
                          output bit ill);
    int a = 0;
    logic [15:0] instr;
    expItem_t it;
    nExec = 0;
    ill = 1'b0;
    forever begin
      instr = rom[a];
      it.idx = n0 + 2 + 3 * nExec;
      it.pc = 11'(a);
      it.op = instr[15:11];
      it.operand = instr[10:0];
      it.ext = 16'($signed(instr[10:0]));
      mainQ.push_back(it);
      nExec++;
      if (!continues(instr[15:11]) || nExec >= 2048) begin
        ill = (instr[15:11] != 5'd0);
        break;
      end
      a = (a + 1) % 2048;
    end
    haltPc = 11'(a);
  endtask

  task automatic waitCount(input int c);
    while (negCount < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Start the program, optionally poke i_start mid-run, check the halt state.
  task automatic runProgram(input int midOffset);
    int n0, nExec, cyc;
    logic [10:0] haltPc;
    bit ill;
    @(negedge clk); #1;
    start = 1'b1;
    n0 = negCount;
    runModel(n0, nExec, haltPc, ill);
    @(negedge clk); #1;
    start = 1'b0;
    check("start_pc", 32'(pc), 0);
    check("start_illegal", 32'(illegal), 0);
    check("start_cycles", 32'(cycles), 0);
    check("fetch_rom_en", 32'(romEn), 1);
    if (midOffset > 0 && midOffset < 3 * nExec - 1) begin
      waitCount(n0 + 1 + midOffset);
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    waitCount(n0 + 3 * nExec + 1);
    cyc = (3 * nExec > 65535) ? 65535 : 3 * nExec;
    check("halt_halted", 32'(halted), 1);
    check("halt_valid", 32'(valid), 0);
    check("halt_pc", 32'(pc), 32'(haltPc));
    check("halt_illegal", 32'(illegal), 32'(ill));
    check("halt_cycles", 32'(cycles), cyc);
    check("scoreboard_drained", mainQ.size(), 0);
  endtask

  initial begin
    int n0, len;
    logic [4:0] op;
    for (int i = 0; i < 2048; i++) rom[i] = '0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("idle_pc", 32'(pc), 0);
    check("idle_rom_en", 32'(romEn), 0);
    check("idle_valid", 32'(valid), 0);
    check("idle_cycles", 32'(cycles), 0);
    check("idle_halted", 32'(halted), 0);

    // Straight-line program: LDI 5, ADDI -1, HALT.
    rom[0] = 16'h1805; rom[1] = 16'h2FFF; rom[2] = 16'h0000;
    runProgram(0);

    // Illegal opcode, started from HALT.
    rom[0] = 16'hF800;
    runProgram(0);

    // Restart from HALT after an illegal stop; i_start poked mid-run.
    rom[0] = 16'h1805;
    runProgram(4);

    // Async reset during DECODE of the second instruction.
    @(negedge clk); #1;
    start = 1'b1;
    n0 = negCount;
    begin
      int ne; logic [10:0] hp; bit il;
      runModel(n0, ne, hp, il);
    end
    @(negedge clk); #1;
    start = 1'b0;
    waitCount(n0 + 5);
    check("pre_reset_ir", 32'(opcode), 32'h3);
    rst_n = 1'b0;
    #1;
    check("reset_outputs",
          32'({pc, romAddr, romEn, opcode, valid, halted, illegal}), 0);
    check("reset_ir_operand", 32'({operand, operandExt}), 0);
    check("reset_cycles", 32'(cycles), 0);
    mainQ.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    runProgram(0);

    // Randomised programs, each started from HALT.
    for (int t = 0; t < 15; t++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len - 1; i++) begin
        op = 5'($urandom_range(1, 7));
        rom[i] = {op, 11'($urandom)};
      end
      op = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(8, 31));
      rom[len - 1] = {op, 11'($urandom)};
      runProgram($urandom_range(0, 3 * len));
    end

    // PC wrap and counter saturation on the auxiliary instances.
    for (int k = 0; k < 6; k++) wrapQ.push_back(2'(k % 4));
    wrapOn = 1'b1;
    @(negedge clk); #1;
    auxRst_n = 1'b1;
    @(negedge clk); #1;
    auxStart = 1'b1;
    n0 = negCount;
    @(negedge clk); #1;
    auxStart = 1'b0;
    check("sat_cycles_0", 32'(sCycles), 0);
    waitCount(n0 + 1 + 10);
    check("sat_cycles_10", 32'(sCycles), 10);
    waitCount(n0 + 1 + 18);
    check("wrap_drained", wrapQ.size(), 0);
    check("wrap_running", 32'(wHalted), 0);
    wrapOn = 1'b0;
    waitCount(n0 + 1 + 20);
    check("sat_cycles_20", 32'(sCycles), 15);
    waitCount(n0 + 1 + 40);
    check("sat_cycles_40", 32'(sCycles), 15);
    check("sat_running", 32'(sHalted), 0);
    auxRst_n = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
